// File: rtl/fanout_fork_ctrl.sv
// fanout_fork_ctrl: registered one-token fork that broadcasts a producer stream to NUM_OUT consumers
//   clk, rst_n          clock and async active-low reset
//   flush               sync clear of held token and ack state
//   cfg_en              branch enable mask, captured when a token is loaded
//   in_valid/in_data    producer side, in_ready back to producer
//   out_valid/out_data  per-branch valid and shared held token, out_ready per branch
//   stall_clr/stall_cnt saturating count of cycles a held token waited on some branch
module fanout_fork_ctrl #(
  parameter int NUM_OUT = 7,
  parameter int DATA_W  = 16,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic [NUM_OUT-1:0] cfg_en,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  output logic               in_ready,
  output logic [NUM_OUT-1:0] out_valid,
  output logic [DATA_W-1:0]  out_data,
  input  logic [NUM_OUT-1:0] out_ready,
  input  logic               stall_clr,
  output logic [CNT_W-1:0]   stall_cnt
);
  logic               r_full;
  logic [DATA_W-1:0]  r_data;
  logic [NUM_OUT-1:0] r_en;
  logic [NUM_OUT-1:0] r_acked;
  logic [CNT_W-1:0]   r_stall;
  logic [NUM_OUT-1:0] w_done;
  logic               w_all_done;
  logic               w_load;
  // a branch is done if disabled, already served, or accepting right now
  assign w_done     = ~r_en | r_acked | out_ready;
  assign w_all_done = r_full & (&w_done);
  assign in_ready   = ~flush & (~r_full | w_all_done);
  assign w_load     = in_valid & in_ready;
  assign out_valid  = {NUM_OUT{r_full}} & r_en & ~r_acked;
  assign out_data   = r_data;
  assign stall_cnt  = r_stall;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full  <= 1'b0;
      r_data  <= '0;
      r_en    <= '0;
      r_acked <= '0;
    end else if (flush) begin
      r_full  <= 1'b0;
      r_acked <= '0;
    end else if (w_load) begin
      r_full  <= 1'b1;
      r_data  <= in_data;
      r_en    <= cfg_en;
      r_acked <= '0;
    end else if (w_all_done) begin
      r_full  <= 1'b0;
      r_acked <= '0;
    end else begin
      r_acked <= r_acked | (out_valid & out_ready);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_stall <= '0;
    else if (stall_clr)
      r_stall <= '0;
    else if (r_full & ~w_all_done & ~flush & ~(&r_stall))
      r_stall <= r_stall + 1'b1;
  end
endmodule
